// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. It generates sequential fetch PCs, issues requests
// over a req/gnt/rvalid instruction-memory interface, and buffers the returned
// instructions in a BUF_DEPTH-entry FIFO. The FIFO feeds the IF/ID register
// that the decode stage reads.
//
// Parameters
//   RESET_PC   fetch address loaded on reset
//   BUF_DEPTH  FIFO entries; also the maximum number of requests that may be in
//              flight or buffered at once (power of 2, >= 2)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   hazard, stall_mem         hold the IF/ID register and the FIFO head
//   redirect, redirect_pc     flush and refetch from redirect_pc (word aligned)
//   imem_req/addr/gnt         request channel to instruction memory
//   imem_rvalid/rdata         in-order response channel
//   instruction, curr_pc,
//   next_pc, valid_if_id      IF/ID register contents
//
// Optional feature (macro FETCH_PERF_EN)
//   bubble_cnt    advance cycles with an empty FIFO and no redirect (saturating)
//   redirect_cnt  redirect cycles (saturating)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        stall_mem,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] curr_pc,
  output logic [31:0] next_pc,
  output logic        valid_if_id
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  localparam int unsigned PW      = $clog2(BUF_DEPTH);
  localparam int unsigned CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP, pc: 32'h0, npc: 32'h0, valid: 1'b0};

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;     // responses still due from memory (stale included)
  logic [CW-1:0] drop_q, drop_d;   // responses to discard after a redirect
  logic [CW-1:0] cnt_q, cnt_d;     // FIFO occupancy
  logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  ifid_t         ifid_q, ifid_d;

  logic [31:0] pcq_mem        [BUF_DEPTH];  // PCs of live requests awaiting data
  logic [31:0] fifo_instr_mem [BUF_DEPTH];
  logic [31:0] fifo_pc_mem    [BUF_DEPTH];

  logic [CW:0] occ;
  logic        gnt_fire, rsp_any, rsp_keep, advance, fifo_empty, pop;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign occ        = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req   = ~rst & ~redirect & (drop_q == '0) & (occ < DEPTH_C);
  assign imem_addr  = fetch_pc_q;
  assign gnt_fire   = imem_req & imem_gnt;
  // A response with nothing in flight is a protocol error; ignoring it keeps
  // the counters from underflowing.
  assign rsp_any    = imem_rvalid & (out_q != '0);
  assign rsp_keep   = rsp_any & (drop_q == '0) & ~redirect;
  assign advance    = ~hazard & ~stall_mem;
  assign fifo_empty = (cnt_q == '0);
  assign pop        = advance & ~fifo_empty & ~redirect;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can
    // leave it unassigned and infer a latch.
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    pcq_wr_d   = pcq_wr_q;
    pcq_rd_d   = pcq_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    ifid_d     = ifid_q;

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // Everything still in flight is stale; a response landing this cycle
      // is discarded directly.
      out_d      = out_q - CW'(rsp_any);
      drop_d     = out_q - CW'(rsp_any);
      cnt_d      = '0;
      pcq_wr_d   = '0;
      pcq_rd_d   = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      ifid_d     = BUBBLE;
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pcq_wr_d   = pcq_wr_q + PW'(1);
      end
      out_d = out_q + CW'(gnt_fire) - CW'(rsp_any);
      if (rsp_any && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (rsp_keep) begin
        pcq_rd_d  = pcq_rd_q + PW'(1);
        fifo_wr_d = fifo_wr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(rsp_keep) - CW'(pop);
      if (pop) begin
        fifo_rd_d    = fifo_rd_q + PW'(1);
        ifid_d.instr = fifo_instr_mem[fifo_rd_q];
        ifid_d.pc    = fifo_pc_mem[fifo_rd_q];
        ifid_d.npc   = fifo_pc_mem[fifo_rd_q] + 32'd4;
        ifid_d.valid = 1'b1;
      end else if (advance) begin
        ifid_d = BUBBLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      ifid_q     <= BUBBLE;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      ifid_q     <= ifid_d;
    end
  end

  // NOTE: the storage arrays are deliberately not reset; an entry is only read
  // after it has been written, as tracked by the reset pointers and counts.
  always_ff @(posedge clk) begin
    if (gnt_fire) begin
      pcq_mem[pcq_wr_q] <= fetch_pc_q;
    end
    if (rsp_keep) begin
      fifo_instr_mem[fifo_wr_q] <= imem_rdata;
      fifo_pc_mem[fifo_wr_q]    <= pcq_mem[pcq_rd_q];
    end
  end

  assign instruction = ifid_q.instr;
  assign curr_pc     = ifid_q.pc;
  assign next_pc     = ifid_q.npc;
  assign valid_if_id = ifid_q.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (advance && fifo_empty && !redirect && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
      if (redirect && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign bubble_cnt   = bubble_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  // Performance counters are not built.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed testbench for fetch_stage. A small memory model grants per imem_gnt
// and answers each granted request one cycle later with data ~address, unless
// hold_resp stalls responses. Each scenario task checks IF/ID and request
// outputs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        hazard;
  logic        stall_mem;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] curr_pc;
  logic [31:0] next_pc;
  logic        valid_if_id;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] redirect_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  bit          hold_resp;
  int          redirects_issued = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .hazard      (hazard),
    .stall_mem   (stall_mem),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .curr_pc     (curr_pc),
    .next_pc     (next_pc),
    .valid_if_id (valid_if_id)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt   (bubble_cnt),
    .redirect_cnt (redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: capture grants at the edge, answer at the following negedge.
  initial begin
    logic [31:0] pend[$];
    bit          present;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pend.delete();
        present = 1'b0;
      end else begin
        if (imem_req && imem_gnt) pend.push_back(imem_addr);
        present = !hold_resp && (pend.size() > 0);
      end
      @(negedge clk);
      if (present) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~pend.pop_front();
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic wait_valid(input int budget, output bit found, output int waited);
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited++;
      if (valid_if_id) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hazard = 1'b0; stall_mem = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_gnt = 1'b1; hold_resp = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_if_id); end
    checks++; if (instruction !== 32'h13) begin errors++; $display("FAIL reset_instr got %h exp 00000013", instruction); end
    checks++; if (curr_pc !== 32'h0) begin errors++; $display("FAIL reset_curr_pc got %h exp 0", curr_pc); end
    checks++; if (next_pc !== 32'h0) begin errors++; $display("FAIL reset_next_pc got %h exp 0", next_pc); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL post_reset_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_sequential();
    bit found;
    int waited;
    exp_pc = 32'h0;
    for (int n = 0; n < 8; n++) begin
      wait_valid(10, found, waited);
      checks++;
      if (!found) begin
        errors++; $display("FAIL seq_timeout n=%0d exp_pc %h", n, exp_pc);
      end else begin
        if (n == 0) begin
          checks++; if (waited != 3) begin errors++; $display("FAIL seq_first_latency got %0d exp 3", waited); end
        end
        checks++; if (curr_pc !== exp_pc) begin errors++; $display("FAIL seq_curr_pc got %h exp %h", curr_pc, exp_pc); end
        checks++; if (instruction !== ~exp_pc) begin errors++; $display("FAIL seq_instr got %h exp %h", instruction, ~exp_pc); end
        checks++; if (next_pc !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_next_pc got %h exp %h", next_pc, exp_pc + 32'd4); end
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_hazard();
    bit          found;
    int          waited;
    logic [31:0] held;
    held   = exp_pc - 32'd4;
    hazard = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin hazard = 1'b0; stall_mem = 1'b1; end
      @(negedge clk);
      checks++; if (curr_pc !== held) begin errors++; $display("FAIL hold_curr_pc i=%0d got %h exp %h", i, curr_pc, held); end
      checks++; if (instruction !== ~held) begin errors++; $display("FAIL hold_instr i=%0d got %h exp %h", i, instruction, ~held); end
      checks++; if (valid_if_id !== 1'b1) begin errors++; $display("FAIL hold_valid i=%0d got %b exp 1", i, valid_if_id); end
      if (i >= 2) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req_full i=%0d got %b exp 0", i, imem_req); end
      end
    end
    stall_mem = 1'b0;
    for (int n = 0; n < 4; n++) begin
      wait_valid((n == 0) ? 1 : 6, found, waited);
      checks++;
      if (!found) begin
        errors++; $display("FAIL release_timeout n=%0d exp_pc %h", n, exp_pc);
      end else begin
        checks++; if (curr_pc !== exp_pc) begin errors++; $display("FAIL release_curr_pc got %h exp %h", curr_pc, exp_pc); end
        checks++; if (instruction !== ~exp_pc) begin errors++; $display("FAIL release_instr got %h exp %h", instruction, ~exp_pc); end
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    bit found;
    int waited;
    hold_resp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_if_id) begin
        checks++; if (curr_pc !== exp_pc) begin errors++; $display("FAIL drain_curr_pc got %h exp %h", curr_pc, exp_pc); end
        checks++; if (instruction !== ~exp_pc) begin errors++; $display("FAIL drain_instr got %h exp %h", instruction, ~exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL outstanding_full_req got %b exp 0", imem_req); end
    checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL outstanding_full_valid got %b exp 0", valid_if_id); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103; hold_resp = 1'b0; redirects_issued++;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_cycle_req got %b exp 0", imem_req); end
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      if (j == 0) redirect = 1'b0;
      #1;
      if (j < 5) begin
        checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL redir_bubble_valid j=%0d got %b exp 0", j, valid_if_id); end
        checks++; if (instruction !== 32'h13) begin errors++; $display("FAIL redir_bubble_instr j=%0d got %h exp 00000013", j, instruction); end
        checks++; if (curr_pc !== 32'h0) begin errors++; $display("FAIL redir_bubble_pc j=%0d got %h exp 0", j, curr_pc); end
      end
      if (j < 2) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_drop_req j=%0d got %b exp 0", j, imem_req); end
      end
      if (j == 2) begin
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_new_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_new_addr got %h exp 00000100", imem_addr); end
      end
      if (j == 5) begin
        checks++; if (valid_if_id !== 1'b1) begin errors++; $display("FAIL redir_first_valid got %b exp 1", valid_if_id); end
        checks++; if (curr_pc !== 32'h100) begin errors++; $display("FAIL redir_first_pc got %h exp 00000100", curr_pc); end
        checks++; if (instruction !== ~32'h100) begin errors++; $display("FAIL redir_first_instr got %h exp %h", instruction, ~32'h100); end
        checks++; if (next_pc !== 32'h104) begin errors++; $display("FAIL redir_first_next got %h exp 00000104", next_pc); end
      end
    end
    exp_pc = 32'h104;
    for (int n = 0; n < 3; n++) begin
      wait_valid(6, found, waited);
      checks++;
      if (!found || curr_pc !== exp_pc || instruction !== ~exp_pc) begin
        errors++; $display("FAIL redir_follow found=%0d got %h/%h exp %h", found, curr_pc, instruction, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_gnt_stall();
    bit          found;
    int          waited;
    logic [31:0] base_bubbles;
    base_bubbles = 32'h0;
    hazard = 1'b1;
    repeat (4) @(negedge clk);
    hazard = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200; imem_gnt = 1'b0; redirects_issued++;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 0) redirect = 1'b0;
      if (j == 5) imem_gnt = 1'b1;
      #1;
`ifdef FETCH_PERF_EN
      if (j == 0) base_bubbles = bubble_cnt;
      if (j == 7) begin
        checks++; if (bubble_cnt - base_bubbles !== 32'd7) begin errors++; $display("FAIL perf_bubbles got %0d exp 7", bubble_cnt - base_bubbles); end
      end
`endif
      if (j <= 5) begin
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_req j=%0d got %b exp 1", j, imem_req); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL stall_addr j=%0d got %h exp 00000200", j, imem_addr); end
      end
      if (j <= 7) begin
        checks++; if (valid_if_id !== 1'b0 || instruction !== 32'h13) begin
          errors++; $display("FAIL stall_bubble j=%0d got %b/%h exp 0/00000013", j, valid_if_id, instruction);
        end
      end else begin
        checks++; if (valid_if_id !== 1'b1 || curr_pc !== 32'h200 || instruction !== ~32'h200) begin
          errors++; $display("FAIL stall_first got %b/%h/%h exp 1/00000200/%h", valid_if_id, curr_pc, instruction, ~32'h200);
        end
      end
    end
    exp_pc = 32'h204;
    for (int n = 0; n < 2; n++) begin
      wait_valid(6, found, waited);
      checks++;
      if (!found || curr_pc !== exp_pc || next_pc !== exp_pc + 32'd4) begin
        errors++; $display("FAIL stall_follow found=%0d got %h/%h exp %h", found, curr_pc, next_pc, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
    if (base_bubbles != 32'h0) exp_pc = exp_pc;
  endtask

  task automatic test_back_to_back();
    bit found;
    int waited;
    redirect = 1'b1; redirect_pc = 32'h0000_0300; redirects_issued++;
    @(negedge clk);
    redirect_pc = 32'h0000_0400; redirects_issued++;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (valid_if_id !== 1'b0) begin errors++; $display("FAIL b2b_bubble got %b exp 0", valid_if_id); end
    exp_pc = 32'h400;
    for (int n = 0; n < 3; n++) begin
      wait_valid(12, found, waited);
      checks++;
      if (!found || curr_pc !== exp_pc || instruction !== ~exp_pc) begin
        errors++; $display("FAIL b2b_seq found=%0d got %h/%h exp %h", found, curr_pc, instruction, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_wrap();
    bit found;
    int waited;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; redirects_issued++;
    @(negedge clk);
    redirect = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    for (int n = 0; n < 3; n++) begin
      wait_valid(12, found, waited);
      checks++;
      if (!found || curr_pc !== exp_pc || instruction !== ~exp_pc || next_pc !== exp_pc + 32'd4) begin
        errors++; $display("FAIL wrap_seq found=%0d got %h/%h/%h exp pc %h", found, curr_pc, instruction, next_pc, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
`ifdef FETCH_PERF_EN
    checks++; if (redirect_cnt !== 32'(redirects_issued)) begin errors++; $display("FAIL perf_redirects got %0d exp %0d", redirect_cnt, redirects_issued); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hazard();
    test_redirect();
    test_gnt_stall();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
